// File: rtl/scan_seq8.sv
// Round-robin channel scanner driving a 3-to-8 enable decoder's select and enable.
// Define SCAN_BLANK_EN to insert one blanking cycle (en low) on every channel change.
module scan_seq8 #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               wrap
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

    state_t             r_state;
    logic [2:0]         r_sel;
    logic               r_en;
    logic               r_busy;
    logic               r_wrap;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;

    logic [2:0]         w_lowSel;
    logic [2:0]         w_nextSel;
    logic [2:0]         w_idx;
    logic               w_found;
    logic [DWELL_W-1:0] w_lastCnt;
    logic               w_chanEnd;

    // Search order starts after the current channel and ends on it, so a single-bit mask re-selects itself.
    always_comb begin
        w_found   = 1'b0;
        w_nextSel = r_sel;
        w_idx     = r_sel;
        for (int i = 1; i <= 8; i++) begin
            w_idx = r_sel + 3'(i);
            if (!w_found && chan_mask[w_idx]) begin
                w_found   = 1'b1;
                w_nextSel = w_idx;
            end
        end
    end

    always_comb begin
        w_lowSel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (chan_mask[i]) begin
                w_lowSel = 3'(i);
            end
        end
    end

    assign w_lastCnt = (r_dwell == '0) ? '0 : r_dwell - DWELL_W'(1);
    assign w_chanEnd = (r_cnt == w_lastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 3'd0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_wrap  <= 1'b0;
            r_cnt   <= '0;
            r_dwell <= '0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_en   <= 1'b0;
                    r_busy <= 1'b0;
                    if (start && !stop && (chan_mask != 8'd0)) begin
                        r_state <= ACTIVE;
                        r_sel   <= w_lowSel;
                        r_dwell <= dwell;
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_chanEnd) begin
                        if (!w_found) begin
                            r_state <= IDLE;
                            r_en    <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_sel   <= w_nextSel;
                            r_cnt   <= '0;
                            r_dwell <= dwell;
                            r_wrap  <= (w_nextSel <= r_sel);
                            r_busy  <= 1'b1;
`ifdef SCAN_BLANK_EN
                            r_state <= BLANK;
                            r_en    <= 1'b0;
`else
                            r_state <= ACTIVE;
                            r_en    <= 1'b1;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + DWELL_W'(1);
                    end
                end
`ifdef SCAN_BLANK_EN
                BLANK: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ACTIVE;
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel  = r_sel;
    assign en   = r_en;
    assign busy = r_busy;
    assign wrap = r_wrap;

endmodule
